// File: rtl/fc_event_queue_pkg.sv
// rtl/fc_event_queue_pkg.sv - shared types, default sizes and ID mapping for the FC event queue
//
// Purpose : default configuration constants, ID/pointer typedefs and the
//           source-index to event-ID mapping used by fc_event_queue.
// Ports   : none (package).

package fc_event_queue_pkg;

  localparam int NB_SOURCES_DEF     = 32;
  localparam int EVENT_ID_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF     = 8;
  localparam int FIFO_AW            = $clog2(FIFO_DEPTH_DEF);

  typedef logic [EVENT_ID_WIDTH_DEF-1:0] evt_id_t;
  typedef logic [FIFO_AW-1:0]            fifo_ptr_t;

  // Event ID carried for a given source index.
  function automatic int unsigned src2id(input int unsigned id_base,
                                         input int unsigned src);
    return id_base + src;
  endfunction

endpackage

// File: rtl/fc_event_queue_arb.sv
// rtl/fc_event_queue_arb.sv - single-grant arbiter over pending event sources
//
// Purpose : picks at most one pending source per cycle while pushing is
//           allowed. Round-robin by default; fixed priority (lowest index
//           wins, no pointer state) when FC_EVENT_QUEUE_FIXED_PRIO_EN is
//           defined.
// Ports   : clk, rst      clock, synchronous active-high reset
//           pend          pending request vector
//           allow         FIFO can take a push this cycle
//           grant         one-hot grant (combinational)
//           grant_idx     binary index of the granted source

module fc_event_queue_arb #(
  parameter int NB_SOURCES = 32,
  localparam int GW = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_SOURCES-1:0] pend,
  input  logic                  allow,
  output logic [NB_SOURCES-1:0] grant,
  output logic [GW-1:0]         grant_idx
);

`ifdef FC_EVENT_QUEUE_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    if (allow) begin
      for (int i = 0; i < NB_SOURCES; i++) begin
        if (!found && pend[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = GW'(i);
        end
      end
    end
  end

`else

  logic [GW-1:0] ptr_q;

  // Scan starting at the pointer and wrapping, so the source just after the
  // last winner has the highest priority.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    if (allow) begin
      for (int k = 0; k < NB_SOURCES; k++) begin
        idx = (int'(ptr_q) + k) % NB_SOURCES;
        if (!found && pend[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = GW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|grant) begin
      ptr_q <= (grant_idx == GW'(NB_SOURCES - 1)) ? '0 : grant_idx + GW'(1);
    end
  end

`endif

endmodule

// File: rtl/fc_event_queue.sv
// rtl/fc_event_queue.sv - event pulse collector, arbiter and ID FIFO feeding the FC event port
//
// Purpose : latches single-cycle event pulses into pending bits, arbitrates
//           one pending source per cycle into a show-ahead ID FIFO and drives
//           the FC interrupt controller event FIFO port. Lost events are
//           recorded in sticky overflow bits.
//           Build option FC_EVENT_QUEUE_FIXED_PRIO_EN selects a fixed
//           priority arbiter instead of round-robin.
// Ports   : clk_i, rst_i          clock, synchronous active-high reset
//           evt_pulse_i          one event per source per high cycle
//           event_fifo_valid_o   head ID valid
//           event_fifo_data_o    head ID (0 when empty)
//           event_fifo_fulln_i   consumer may accept the head
//           overflow_o           sticky per-source event-lost flags
//           overflow_clr_i       write-one-to-clear for overflow_o
//           fifo_level_o         FIFO occupancy

module fc_event_queue
  import fc_event_queue_pkg::*;
#(
  parameter int          NB_SOURCES     = NB_SOURCES_DEF,
  parameter int          EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
  parameter int          FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned ID_BASE        = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NB_SOURCES-1:0]         evt_pulse_i,
  output logic                          event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0]     event_fifo_data_o,
  input  logic                          event_fifo_fulln_i,
  output logic [NB_SOURCES-1:0]         overflow_o,
  input  logic [NB_SOURCES-1:0]         overflow_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1;

  if (64'(ID_BASE) + 64'(NB_SOURCES) > (64'd1 << EVENT_ID_WIDTH)) begin : g_id_range_err
    $error("fc_event_queue: ID_BASE+NB_SOURCES exceeds the event ID space");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
    $error("fc_event_queue: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [NB_SOURCES-1:0]     pend_q;
  logic [NB_SOURCES-1:0]     ovf_q;
  logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [LW-1:0]             level_q;

  logic [NB_SOURCES-1:0]     grant;
  logic [GW-1:0]             grant_idx;
  logic                      valid;
  logic                      push;
  logic                      pop;
  logic                      allow;
  logic [EVENT_ID_WIDTH-1:0] push_id;

  assign valid   = (level_q != '0);
  assign pop     = valid & event_fifo_fulln_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign allow   = (level_q < LW'(FIFO_DEPTH)) | pop;
  assign push    = |grant;
  assign push_id = EVENT_ID_WIDTH'(src2id(ID_BASE, 32'(grant_idx)));

  fc_event_queue_arb #(
    .NB_SOURCES (NB_SOURCES)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .pend      (pend_q),
    .allow     (allow),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // A pulse on a source granted this edge re-arms it; a pulse on a source
      // that stays pending is lost. Loss wins over a same-edge clear.
      pend_q <= (pend_q & ~grant) | evt_pulse_i;
      ovf_q  <= (ovf_q & ~overflow_clr_i) | (evt_pulse_i & pend_q & ~grant);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while level is nonzero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_id;
  end

  assign event_fifo_valid_o = valid;
  assign event_fifo_data_o  = valid ? mem_q[rd_ptr_q] : '0;
  assign overflow_o         = ovf_q;
  assign fifo_level_o       = level_q;

endmodule

// File: tb/tb_fc_event_queue.sv
// tb/tb_fc_event_queue.sv - directed self-checking bench for fc_event_queue

module tb_fc_event_queue;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] evt;
  logic         valid;
  logic [7:0]   data;
  logic         fulln;
  logic [N-1:0] ovf;
  logic [N-1:0] clr;
  logic [3:0]   level;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fc_event_queue dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .evt_pulse_i        (evt),
    .event_fifo_valid_o (valid),
    .event_fifo_data_o  (data),
    .event_fifo_fulln_i (fulln),
    .overflow_o         (ovf),
    .overflow_clr_i     (clr),
    .fifo_level_o       (level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_id;
    rst   = 1'b1;
    evt   = '0;
    fulln = 1'b0;
    clr   = '0;
    #1;

    // 1: reset held two cycles with pulses active
    evt = '1;
    step();
    step();
    rst = 1'b0;
    evt = '0;
    step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data",  32'(data),  32'd0);
    chk("rst_ovf",   ovf,        32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // 2: single event from source 5
    fulln  = 1'b1;
    evt[5] = 1'b1;
    step();
    evt = '0;
    chk("single_not_yet", 32'(valid), 32'd0);
    step();
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_data",  32'(data),  32'h05);
    chk("single_level", 32'(level), 32'd1);
    step();
    chk("single_gone",  32'(valid), 32'd0);
    chk("single_level0", 32'(level), 32'd0);
    chk("single_data0", 32'(data),  32'd0);

    // 3: back-pressure and full FIFO
    do_reset();
    fulln = 1'b0;
    evt   = 32'h0000_03FF;
    step();
    evt = '0;
    for (int i = 0; i < 10; i++) step();
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovf",   ovf,        32'd0);
    chk("full_head",  32'(data),  32'd0);
    evt[9] = 1'b1;
    step();
    evt = '0;
    chk("full_ovf9", ovf, 32'h0000_0200);
    chk("full_level_hold", 32'(level), 32'd8);
    fulln = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(valid), 32'd1);
      chk($sformatf("drain_data_%0d", i),  32'(data),  32'(i));
      step();
    end
    chk("drain_empty", 32'(valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    clr[9] = 1'b1;
    step();
    clr = '0;
    chk("drain_ovf_clr", ovf, 32'd0);

    // 4: all sources pulsed continuously
    do_reset();
    fulln = 1'b1;
    evt   = '1;
    step();
    step();
    for (int j = 0; j < 33; j++) begin
`ifdef FC_EVENT_QUEUE_FIXED_PRIO_EN
      exp_id = 32'd0;
`else
      exp_id = 32'(j % 32);
`endif
      chk($sformatf("order_%0d", j), 32'(data), exp_id);
      step();
    end
`ifdef FC_EVENT_QUEUE_FIXED_PRIO_EN
    chk("fair_ovf", ovf, 32'hFFFF_FFFE);
`else
    chk("fair_ovf", ovf, 32'hFFFF_FFFF);
`endif
    chk("fair_level", 32'(level), 32'd1);
    evt = '0;

    // 5: pulse coincident with grant, then set-over-clear
    do_reset();
    fulln  = 1'b1;
    evt[3] = 1'b1;
    step();
    step();
    evt = '0;
    chk("coin_ovf",   ovf,        32'd0);
    chk("coin_data1", 32'(data),  32'h03);
    step();
    chk("coin_data2", 32'(data),  32'h03);
    chk("coin_level", 32'(level), 32'd1);
    step();
    chk("coin_empty", 32'(valid), 32'd0);
    evt = 32'h0000_000C;
    step();
    evt    = 32'h0000_0008;
    clr[3] = 1'b1;
    step();
    evt = '0;
    clr = '0;
    chk("setclr_ovf", ovf, 32'h0000_0008);
    chk("setclr_first",  32'(data), 32'h02);
    step();
    chk("setclr_second", 32'(data), 32'h03);
    step();
    chk("setclr_empty", 32'(valid), 32'd0);
    clr[3] = 1'b1;
    step();
    clr = '0;
    chk("setclr_cleared", ovf, 32'd0);

    // 6: reset in the middle of operation
    fulln = 1'b0;
    evt   = 32'h0000_003F;
    step();
    evt = '0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_level5", 32'(level), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_level0", 32'(level), 32'd0);
    chk("mid_valid0", 32'(valid), 32'd0);
    chk("mid_ovf0",   ovf,        32'd0);
    step();
    step();
    chk("mid_pend_gone", 32'(level), 32'd0);
    fulln  = 1'b1;
    evt[7] = 1'b1;
    step();
    evt = '0;
    step();
    chk("mid_valid7", 32'(valid), 32'd1);
    chk("mid_data7",  32'(data),  32'h07);
    step();
    chk("mid_end", 32'(valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
